// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks (divider, multiplier).
// Holds the common state encoding and the default operand width.
package seq_arith_pkg;

    localparam int DEFAULT_N = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div_chk.sv
// Combinational special-case detection for the signed divider.
// Flags divide-by-zero and the single overflowing operand pair (-2^(N-1) / -1).
module seq_div_chk #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         div_zero,
    output logic         ovf
);

    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    assign div_zero = (b == '0);
    assign ovf      = (a == MOST_NEG) && (b == '1);

endmodule

// File: rtl/seq_div.sv
// Signed N-bit sequential divider: restoring division on magnitudes, one quotient
// bit per cycle, fixed latency of N+1 cycles from the accepting edge to valid.
module seq_div
    import seq_arith_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         valid,
    output logic         busy,
    output logic         error
);

    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [N:0]     rem;
    logic [N-1:0]   dq;
    logic [N-1:0]   mb;
    logic [N-1:0]   a_hold;
    logic           neg_q;
    logic           neg_r;
    logic           dz_hold;
    logic           ovf_hold;

    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic [N:0]     shifted;
    logic [N:0]     diff;
    logic           div_zero;
    logic           ovf;

    seq_div_chk #(.N(N)) u_chk (
        .a        (a),
        .b        (b),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        mag_a   = a[N-1] ? (~a + ONE) : a;
        mag_b   = b[N-1] ? (~b + ONE) : b;
        // Next dividend bit enters the partial remainder from dq's MSB.
        shifted = (rem << 1) | {{N{1'b0}}, dq[N-1]};
        diff    = shifted - {1'b0, mb};
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            error    <= 1'b0;
            q        <= '0;
            r        <= '0;
            rem      <= '0;
            dq       <= '0;
            mb       <= '0;
            a_hold   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_hold  <= 1'b0;
            ovf_hold <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_hold   <= a;
                        dq       <= mag_a;
                        mb       <= mag_b;
                        rem      <= '0;
                        neg_q    <= a[N-1] ^ b[N-1];
                        neg_r    <= a[N-1];
                        dz_hold  <= div_zero;
                        ovf_hold <= ovf;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // A negative trial difference means restore; its borrow bit is the inverted quotient bit.
                    rem <= diff[N] ? shifted : diff;
                    dq  <= {dq[N-2:0], ~diff[N]};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    valid <= 1'b1;
                    error <= dz_hold | ovf_hold;
                    if (dz_hold) begin
                        q <= '1;
                        r <= a_hold;
                    end else begin
                        // The overflow pair lands here too: 2^(N-1) read back as signed is -2^(N-1).
                        q <= neg_q ? (~dq + ONE) : dq;
                        r <= neg_r ? (~rem[N-1:0] + ONE) : rem[N-1:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (N=5): arithmetic reference model checked every
// cycle, plus directed operations with hand-computed literal results and latency.
module tb_seq_div;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         valid;
    logic         busy;
    logic         error;

    int tests_run = 0;
    int tests_failed = 0;
    bit checking = 1'b0;

    seq_div #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .valid (valid),
        .busy  (busy),
        .error (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: truncating signed division with the two special cases.
    function automatic void model_div(input logic [N-1:0] x, input logic [N-1:0] y,
                                      output logic [N-1:0] qq, output logic [N-1:0] rr,
                                      output logic ee);
        int sx;
        int sy;
        sx = $signed(x);
        sy = $signed(y);
        if (sy == 0) begin
            qq = '1;
            rr = x;
            ee = 1'b1;
        end else if (sx == -(2 ** (N - 1)) && sy == -1) begin
            qq = x;
            rr = '0;
            ee = 1'b1;
        end else begin
            qq = N'(sx / sy);
            rr = N'(sx % sy);
            ee = 1'b0;
        end
    endfunction

    // Transaction-level model: an accepted operation resolves N+1 edges later.
    logic [N-1:0] m_q = '0;
    logic [N-1:0] m_r = '0;
    logic         m_err = 1'b0;
    logic         m_valid = 1'b0;
    logic         m_busy = 1'b0;
    bit           pend = 1'b0;
    int           left = 0;
    logic [N-1:0] op_a = '0;
    logic [N-1:0] op_b = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_q = '0; m_r = '0; m_err = 1'b0; m_valid = 1'b0; m_busy = 1'b0;
            pend = 1'b0; left = 0;
        end else begin
            m_valid = 1'b0;
            if (pend) begin
                left--;
                if (left == 0) begin
                    pend = 1'b0;
                    m_valid = 1'b1;
                    model_div(op_a, op_b, m_q, m_r, m_err);
                end
            end else if (start) begin
                pend = 1'b1;
                left = N + 1;
                op_a = a;
                op_b = b;
            end
            m_busy = pend && (left > 1);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("valid", {31'b0, valid}, {31'b0, m_valid});
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            check("q", {27'b0, q}, {27'b0, m_q});
            check("r", {27'b0, r}, {27'b0, m_r});
            check("error", {31'b0, error}, {31'b0, m_err});
            check("busy_valid_excl", {31'b0, busy & valid}, 32'd0);
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that raised valid.
    task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input logic ee,
                         input bit poke);
        int cycles;
        start = 1'b1; a = ta; b = tb_;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        while (!valid && cycles < 20) begin
            if (poke && cycles == 2) begin
                start = 1'b1; a = 5'b00001; b = 5'b00001;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        check("latency", cycles, N + 1);
        check("lit_q", {27'b0, q}, {27'b0, eq});
        check("lit_r", {27'b0, r}, {27'b0, er});
        check("lit_error", {31'b0, error}, {31'b0, ee});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        rst = 1'b1;
        start = 1'b1;
        a = 5'b01111;
        b = 5'b00011;
        @(posedge clk); @(posedge clk); #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_q", {27'b0, q}, 32'd0);
        check("rst_r", {27'b0, r}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        start = 1'b0;
        rst = 1'b0;
        checking = 1'b1;
        idle(1);

        do_op(5'b01111, 5'b00011, 5'b00101, 5'b00000, 1'b0, 1'b0);  // 15 / 3
        idle(2);
        do_op(5'b10011, 5'b00100, 5'b11101, 5'b11111, 1'b0, 1'b0);  // -13 / 4
        idle(1);
        do_op(5'b11010, 5'b00111, 5'b00000, 5'b11010, 1'b0, 1'b0);  // -6 / 7
        idle(3);
        do_op(5'b00101, 5'b00000, 5'b11111, 5'b00101, 1'b1, 1'b0);  // 5 / 0
        idle(1);
        do_op(5'b10000, 5'b11111, 5'b10000, 5'b00000, 1'b1, 1'b0);  // -16 / -1
        idle(1);
        do_op(5'b10000, 5'b00001, 5'b10000, 5'b00000, 1'b0, 1'b0);  // -16 / 1
        idle(1);
        do_op(5'b00111, 5'b11110, 5'b11101, 5'b00001, 1'b0, 1'b0);  // 7 / -2
        idle(1);
        do_op(5'b11001, 5'b11110, 5'b00011, 5'b11111, 1'b0, 1'b0);  // -7 / -2
        idle(4);
        do_op(5'b01111, 5'b00011, 5'b00101, 5'b00000, 1'b0, 1'b1);  // start poked during CALC
        do_op(5'b10011, 5'b00100, 5'b11101, 5'b11111, 1'b0, 1'b0);  // back-to-back
        idle(2);

        // Reset in the middle of CALC aborts the operation.
        start = 1'b1; a = 5'b01110; b = 5'b00011;
        @(posedge clk); #1;
        start = 1'b0;
        idle(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_q", {27'b0, q}, 32'd0);
        check("abort_r", {27'b0, r}, 32'd0);
        vcount = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk); #1;
            if (valid) vcount++;
        end
        check("abort_no_valid", vcount, 0);

        do_op(5'b01100, 5'b11011, 5'b11110, 5'b00010, 1'b0, 1'b0);  // 12 / -5 after abort
        idle(3);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
